// File: rtl/mcycle_pkg.sv
// ============================================================
// mcycle_pkg : shared constants and FSM encoding for mcycle_ctrl
// Rev 1.0
// ============================================================
`default_nettype none

package mcycle_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mcycle_step_cnt.sv
// ============================================================
// mcycle_step_cnt : step counter with clear, enable and last-step flag
// Rev 1.0
// ============================================================
`default_nettype none

module mcycle_step_cnt #(
  parameter int CNT_W = 6,
  parameter int LAST  = 31
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Flags the step cycle whose edge completes the final iteration
  assign o_last = i_en & (r_cnt == CNT_W'(LAST));

endmodule

`default_nettype wire

// File: rtl/mcycle_ctrl.sv
// ============================================================
// mcycle_ctrl : MUL/DIV sequencer driving the iterative datapath
// Rev 1.0
// ============================================================
`default_nettype none

module mcycle_ctrl
  import mcycle_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             M_Start,
  input  logic             MCycleOp,
  input  logic             M_W,
  input  logic             CondEx,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  input  logic [3:0]       WA3_in,
  output logic             dp_load,
  output logic             dp_step,
  output logic             dp_op,
  input  logic [WIDTH-1:0] dp_lo,
  input  logic [WIDTH-1:0] dp_hi,
  output logic             Busy,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             ResultValid,
  output logic             RegWrite,
  output logic [3:0]       WA3
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_op;
  logic             r_mw;
  logic             r_fast;
  logic [3:0]       r_wa3;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;

  logic             w_accept;
  logic             w_divz;
  logic             w_capture;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_last;

  assign w_accept  = (r_state == S_IDLE) & M_Start & CondEx;
  assign w_divz    = w_accept & (MCycleOp == OP_DIV) & (Operand2 == '0);
  assign w_capture = (r_state == S_DONE) & ~r_fast;

  mcycle_step_cnt #(
    .CNT_W (CNT_W),
    .LAST  (WIDTH - 1)
  ) u_step_cnt (
    .clk    (CLK),
    .rst_n  (RESET),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .o_last (w_last)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_op        <= OP_MUL;
      r_mw        <= 1'b0;
      r_fast      <= 1'b0;
      r_wa3       <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op   <= MCycleOp;
        r_mw   <= M_W;
        r_wa3  <= WA3_in;
        r_fast <= w_divz;
      end
      if (w_divz) begin
        r_result    <= '1;
        r_result_hi <= Operand1;
      end else if (w_capture) begin
        r_result    <= dp_lo;
        r_result_hi <= dp_hi;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    dp_load     = 1'b0;
    dp_step     = 1'b0;
    ResultValid = 1'b0;
    RegWrite    = 1'b0;
    Busy        = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        Busy = w_accept;
        if (w_divz) begin
          w_state_nxt = S_DONE;
        end else if (w_accept) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        Busy        = 1'b1;
        dp_load     = 1'b1;
        w_cnt_clr   = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        Busy     = 1'b1;
        dp_step  = 1'b1;
        w_cnt_en = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        ResultValid = 1'b1;
        RegWrite    = r_mw;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath already holds the final-step value in DONE, so forward it
  // combinationally there and keep the registered copy afterwards.
  assign Result   = w_capture ? dp_lo : r_result;
  assign ResultHi = w_capture ? dp_hi : r_result_hi;
  assign dp_op    = r_op;
  assign WA3      = r_wa3;

endmodule

`default_nettype wire

// File: tb/tb_mcycle_ctrl.sv
// ============================================================
// tb_mcycle_ctrl : self-checking bench with behavioural datapath model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_mcycle_ctrl;

  localparam int W    = 32;
  localparam int NLAT = W + 2;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         M_Start = 1'b0;
  logic         MCycleOp = 1'b0;
  logic         M_W = 1'b0;
  logic         CondEx = 1'b0;
  logic [W-1:0] Operand1 = '0;
  logic [W-1:0] Operand2 = '0;
  logic [3:0]   WA3_in = '0;
  logic         dp_load, dp_step, dp_op;
  logic [W-1:0] dp_lo, dp_hi;
  logic         Busy, ResultValid, RegWrite;
  logic [W-1:0] Result, ResultHi;
  logic [3:0]   WA3;

  int checks = 0;
  int errors = 0;
  int n_load = 0;
  int n_step = 0;
  int n_rv   = 0;
  int n_both = 0;

  // Behavioural datapath: answer appears only after exactly W steps
  logic [W-1:0]   m_a = '0;
  logic [W-1:0]   m_b = '0;
  logic           m_op = 1'b0;
  int             m_steps = 0;
  logic [2*W-1:0] m_prod;

  typedef struct {
    int           lat;
    int           busy;
    int           loads;
    int           steps;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         rw;
    logic [3:0]   wa;
    logic         op;
    logic         busy_done;
  } obs_t;

  always #5 CLK = ~CLK;

  mcycle_ctrl #(.WIDTH(W)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .M_Start     (M_Start),
    .MCycleOp    (MCycleOp),
    .M_W         (M_W),
    .CondEx      (CondEx),
    .Operand1    (Operand1),
    .Operand2    (Operand2),
    .WA3_in      (WA3_in),
    .dp_load     (dp_load),
    .dp_step     (dp_step),
    .dp_op       (dp_op),
    .dp_lo       (dp_lo),
    .dp_hi       (dp_hi),
    .Busy        (Busy),
    .Result      (Result),
    .ResultHi    (ResultHi),
    .ResultValid (ResultValid),
    .RegWrite    (RegWrite),
    .WA3         (WA3)
  );

  always @(posedge CLK) begin
    if (dp_load) n_load++;
    if (dp_step) n_step++;
    if (ResultValid) n_rv++;
    if (dp_load && dp_step) n_both++;
    if (dp_load) begin
      m_a     <= Operand1;
      m_b     <= Operand2;
      m_op    <= dp_op;
      m_steps <= 0;
    end else if (dp_step) begin
      m_steps <= m_steps + 1;
    end
  end

  always_comb begin
    m_prod = {{W{1'b0}}, m_a} * {{W{1'b0}}, m_b};
    if (m_steps == W) begin
      if (m_op) begin
        dp_lo = (m_b == '0) ? '1  : m_a / m_b;
        dp_hi = (m_b == '0) ? m_a : m_a % m_b;
      end else begin
        dp_lo = m_prod[W-1:0];
        dp_hi = m_prod[2*W-1:W];
      end
    end else begin
      dp_lo = 32'hA5A5_0000 ^ W'(m_steps);
      dp_hi = 32'h5A5A_0000 ^ W'(m_steps);
    end
  end

  // Issues one instruction held (stalled) until its DONE cycle, then
  // steps to the following IDLE cycle with M_Start dropped.
  task automatic exec_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic op, input logic mw, input logic [3:0] wa,
                         output obs_t o);
    int l0, s0;
    bit found;
    l0 = n_load; s0 = n_step; found = 0;
    o.lat = 0; o.busy = 0; o.res = '0; o.hi = '0;
    o.rw = 1'b0; o.wa = '0; o.op = 1'b0; o.busy_done = 1'b0;
    M_Start = 1'b1; CondEx = 1'b1; MCycleOp = op; M_W = mw;
    Operand1 = a; Operand2 = b; WA3_in = wa;
    while (!found && o.lat < 200) begin
      #1;
      if (ResultValid) begin
        found = 1;
        o.res = Result; o.hi = ResultHi; o.rw = RegWrite;
        o.wa = WA3; o.op = dp_op; o.busy_done = Busy;
      end else begin
        if (Busy) o.busy++;
        o.lat++;
        @(negedge CLK);
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL exec_timeout got no ResultValid want a pulse within 200 cycles");
    end
    @(negedge CLK);
    M_Start = 1'b0; CondEx = 1'b0;
    o.loads = n_load - l0;
    o.steps = n_step - s0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if ({Busy, dp_load, dp_step, ResultValid, RegWrite} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000", {Busy, dp_load, dp_step, ResultValid, RegWrite});
    end
    checks++;
    if ({Result, ResultHi, WA3, dp_op} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h/%b want all zero", Result, ResultHi, WA3, dp_op);
    end
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_mul();
    obs_t o;
    exec_op(32'd7, 32'd6, 1'b0, 1'b1, 4'd3, o);
    checks++; if (o.lat !== NLAT) begin errors++; $display("FAIL mul_latency got %0d want %0d", o.lat, NLAT); end
    checks++; if (o.busy !== NLAT) begin errors++; $display("FAIL mul_busy got %0d want %0d", o.busy, NLAT); end
    checks++; if (o.steps !== W || o.loads !== 1) begin errors++; $display("FAIL mul_pulses got steps=%0d loads=%0d want %0d/1", o.steps, o.loads, W); end
    checks++; if (o.res !== 32'd42 || o.hi !== 32'd0) begin errors++; $display("FAIL mul_result got %h:%h want 0:2a", o.hi, o.res); end
    checks++; if (o.rw !== 1'b1 || o.wa !== 4'd3) begin errors++; $display("FAIL mul_write got rw=%b wa=%0d want 1/3", o.rw, o.wa); end
    checks++; if (o.busy_done !== 1'b0 || o.op !== 1'b0) begin errors++; $display("FAIL mul_done got busy=%b op=%b want 0/0", o.busy_done, o.op); end
    #1;
    checks++; if (ResultValid !== 1'b0 || RegWrite !== 1'b0 || Result !== 32'd42) begin
      errors++; $display("FAIL mul_hold got rv=%b rw=%b res=%h want 0/0/2a", ResultValid, RegWrite, Result);
    end
  endtask

  task automatic test_div();
    obs_t o;
    int   rv0;
    rv0 = n_rv;
    exec_op(32'd100, 32'd7, 1'b1, 1'b1, 4'd5, o);
    checks++; if (o.res !== 32'd14 || o.hi !== 32'd2) begin errors++; $display("FAIL div_result got q=%0d r=%0d want 14/2", o.res, o.hi); end
    checks++; if (o.lat !== NLAT || o.op !== 1'b1) begin errors++; $display("FAIL div_timing got lat=%0d op=%b want %0d/1", o.lat, o.op, NLAT); end
    checks++; if (n_rv - rv0 !== 1) begin errors++; $display("FAIL div_rv_pulse got %0d want 1", n_rv - rv0); end
    exec_op(32'hFFFF_FFFF, 32'h10, 1'b1, 1'b0, 4'd9, o);
    checks++; if (o.res !== 32'h0FFF_FFFF || o.hi !== 32'hF) begin errors++; $display("FAIL div_big got q=%h r=%h want 0fffffff/f", o.res, o.hi); end
    checks++; if (o.rw !== 1'b0 || o.wa !== 4'd9) begin errors++; $display("FAIL div_nowrite got rw=%b wa=%0d want 0/9", o.rw, o.wa); end
  endtask

  task automatic test_divzero();
    obs_t o;
    exec_op(32'd5, 32'd0, 1'b1, 1'b1, 4'd4, o);
    checks++; if (o.lat !== 1 || o.busy !== 1) begin errors++; $display("FAIL divz_latency got lat=%0d busy=%0d want 1/1", o.lat, o.busy); end
    checks++; if (o.loads !== 0 || o.steps !== 0) begin errors++; $display("FAIL divz_pulses got loads=%0d steps=%0d want 0/0", o.loads, o.steps); end
    checks++; if (o.res !== 32'hFFFF_FFFF || o.hi !== 32'd5) begin errors++; $display("FAIL divz_result got %h:%h want 5:ffffffff", o.hi, o.res); end
    checks++; if (o.rw !== 1'b1 || o.wa !== 4'd4) begin errors++; $display("FAIL divz_write got rw=%b wa=%0d want 1/4", o.rw, o.wa); end
  endtask

  task automatic test_condfail();
    int l0, rv0, nbusy, nrw;
    l0 = n_load; rv0 = n_rv; nbusy = 0; nrw = 0;
    M_Start = 1'b1; CondEx = 1'b0; MCycleOp = 1'b0; M_W = 1'b1;
    Operand1 = 32'd3; Operand2 = 32'd0; WA3_in = 4'd1;
    for (int i = 0; i < 6; i++) begin
      MCycleOp = 1'($urandom_range(0, 1));
      #1;
      if (Busy) nbusy++;
      if (RegWrite) nrw++;
      @(negedge CLK);
    end
    M_Start = 1'b0;
    checks++; if (nbusy !== 0 || nrw !== 0) begin errors++; $display("FAIL condfail_busy got busy=%0d rw=%0d want 0/0", nbusy, nrw); end
    checks++; if (n_load - l0 !== 0 || n_rv - rv0 !== 0) begin errors++; $display("FAIL condfail_pulses got load=%0d rv=%0d want 0/0", n_load - l0, n_rv - rv0); end
  endtask

  task automatic test_reset_midrun();
    obs_t o;
    int   s0, rv0, waited;
    s0 = n_step; waited = 0;
    M_Start = 1'b1; CondEx = 1'b1; MCycleOp = 1'b0; M_W = 1'b1;
    Operand1 = 32'd9; Operand2 = 32'd9; WA3_in = 4'd7;
    @(negedge CLK);
    M_Start = 1'b0; CondEx = 1'b0;
    while (n_step - s0 < 10 && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    checks++; if (n_step - s0 !== 10) begin errors++; $display("FAIL midrun_reach got %0d steps want 10", n_step - s0); end
    rv0 = n_rv;
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    checks++;
    if ({Busy, dp_load, dp_step, ResultValid, RegWrite} !== 5'b0) begin
      errors++; $display("FAIL midrun_ctrl got %b want 00000", {Busy, dp_load, dp_step, ResultValid, RegWrite});
    end
    checks++;
    if ({Result, ResultHi, WA3, dp_op} !== '0) begin
      errors++; $display("FAIL midrun_data got %h/%h/%h/%b want all zero", Result, ResultHi, WA3, dp_op);
    end
    repeat (40) @(negedge CLK);
    checks++; if (n_rv - rv0 !== 0) begin errors++; $display("FAIL midrun_norv got %0d want 0", n_rv - rv0); end
    exec_op(32'd3, 32'd4, 1'b0, 1'b1, 4'd2, o);
    checks++; if (o.res !== 32'd12 || o.lat !== NLAT) begin errors++; $display("FAIL midrun_restart got res=%0d lat=%0d want 12/%0d", o.res, o.lat, NLAT); end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    int   rv0;
    rv0 = n_rv;
    exec_op(32'd2, 32'd3, 1'b0, 1'b1, 4'd1, o1);
    exec_op(32'd9, 32'd2, 1'b1, 1'b1, 4'd2, o2);
    checks++; if (o1.res !== 32'd6 || o1.wa !== 4'd1) begin errors++; $display("FAIL b2b_first got res=%0d wa=%0d want 6/1", o1.res, o1.wa); end
    checks++; if (o2.res !== 32'd4 || o2.hi !== 32'd1 || o2.wa !== 4'd2) begin errors++; $display("FAIL b2b_second got q=%0d r=%0d wa=%0d want 4/1/2", o2.res, o2.hi, o2.wa); end
    checks++; if (o2.lat !== NLAT || o2.loads !== 1) begin errors++; $display("FAIL b2b_gap got lat=%0d loads=%0d want %0d/1", o2.lat, o2.loads, NLAT); end
    checks++; if (n_rv - rv0 !== 2) begin errors++; $display("FAIL b2b_rv_count got %0d want 2", n_rv - rv0); end
  endtask

  task automatic test_random();
    obs_t           o;
    logic [W-1:0]   a, b, e_lo, e_hi;
    logic [2*W-1:0] p;
    logic           op, mw;
    logic [3:0]     wa;
    int             e_lat;
    for (int i = 0; i < 16; i++) begin
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
      op = 1'($urandom_range(0, 1));
      mw = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      if (op && b == '0) begin
        e_lo = '1; e_hi = a; e_lat = 1;
      end else if (op) begin
        e_lo = a / b; e_hi = a % b; e_lat = NLAT;
      end else begin
        p = 64'(a) * 64'(b);
        e_lo = p[W-1:0]; e_hi = p[2*W-1:W]; e_lat = NLAT;
      end
      exec_op(a, b, op, mw, wa, o);
      checks++; if (o.res !== e_lo || o.hi !== e_hi) begin errors++; $display("FAIL rand_result[%0d] got %h:%h want %h:%h", i, o.hi, o.res, e_hi, e_lo); end
      checks++; if (o.lat !== e_lat || o.busy !== e_lat) begin errors++; $display("FAIL rand_timing[%0d] got lat=%0d busy=%0d want %0d", i, o.lat, o.busy, e_lat); end
      checks++; if (o.steps !== ((e_lat == 1) ? 0 : W)) begin errors++; $display("FAIL rand_steps[%0d] got %0d want %0d", i, o.steps, (e_lat == 1) ? 0 : W); end
      checks++; if (o.rw !== mw || o.wa !== wa) begin errors++; $display("FAIL rand_write[%0d] got rw=%b wa=%0d want %b/%0d", i, o.rw, o.wa, mw, wa); end
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_divzero();
    test_condfail();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    checks++;
    if (n_both !== 0) begin errors++; $display("FAIL load_step_overlap got %0d want 0", n_both); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
